cursor_navigator: RTL and testbench

- Upstream neighbour of board_updater.
- Owns the 9x9 cursor and moves it with the d-pad while the game is in the NAVEGAR state.
- Drives the bit index and cell value that board_updater consumes.
- A background raster scanner continuously counts solved cells so the top FSM can detect a won board.

---
 rtl/sudoku_pkg.sv | 49 ++++
 rtl/solved_scanner.sv | 45 ++++
 rtl/cursor_navigator.sv | 149 ++++++++++++++
 tb/tb_cursor_navigator.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku game datapath: state codes, grid sizes,
// cell status encodings and cell/index helpers.
package sudoku_pkg;

  localparam logic [2:0] CARREGANDO        = 3'b010;
  localparam logic [2:0] NAVEGAR           = 3'b011;
  localparam logic [2:0] PERCORRER_NUMEROS = 3'b100;

  localparam int GRID  = 9;
  localparam int CELLS = 81;

  localparam logic [6:0] LAST_CELL = 7'd80;

  typedef enum logic [1:0] {
    HIDDEN  = 2'b00,
    VISITED = 2'b01,
    ERROR   = 2'b10,
    SOLVED  = 2'b11
  } vis_t;

  function automatic logic [6:0] cell_of(input logic [3:0] r, input logic [3:0] c);
    return 7'(r) * 7'd9 + 7'(c);
  endfunction

  // Status vectors pack 2 bits per cell, so the bit index is simply 2*k.
  function automatic logic [7:0] index_of(input logic [6:0] k);
    return {k, 1'b0};
  endfunction

  function automatic logic [3:0] row_of(input logic [6:0] k);
    logic [6:0] q;
    q = k / 7'd9;
    return q[3:0];
  endfunction

  function automatic logic [3:0] col_of(input logic [6:0] k);
    logic [6:0] m;
    m = k % 7'd9;
    return m[3:0];
  endfunction

  function automatic logic [6:0] raster_step(input logic [6:0] k, input logic fwd);
    logic [6:0] r;
    if (fwd) r = (k == LAST_CELL) ? 7'd0 : k + 7'd1;
    else     r = (k == 7'd0) ? LAST_CELL : k - 7'd1;
    return r;
  endfunction

endpackage

// File: rtl/solved_scanner.sv
// Background raster scan over all 81 cell statuses; publishes the number of
// solved cells once per 81-cycle pass.
module solved_scanner
  import sudoku_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic [161:0] visibilities,
  output logic [6:0]   solved_count,
  output logic         board_complete
);

  logic [6:0] scan_k;
  logic [6:0] acc;
  logic       hit;
  logic [6:0] total;

  assign hit   = (visibilities[{scan_k, 1'b0} +: 2] == SOLVED);
  assign total = acc + {6'd0, hit};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_k         <= 7'd0;
      acc            <= 7'd0;
      solved_count   <= 7'd0;
      board_complete <= 1'b0;
    end else if (clear) begin
      scan_k         <= 7'd0;
      acc            <= 7'd0;
      solved_count   <= 7'd0;
      board_complete <= 1'b0;
    end else if (scan_k == LAST_CELL) begin
      // Last cell's hit is folded in on the same edge as the publish.
      solved_count   <= total;
      board_complete <= (total == 7'd81);
      acc            <= 7'd0;
      scan_k         <= 7'd0;
    end else begin
      acc    <= total;
      scan_k <= scan_k + 7'd1;
    end
  end

endmodule

// File: rtl/cursor_navigator.sv
// 9x9 cursor driven by the d-pad in NAVEGAR; feeds board_updater with the
// cell bit index and answer value. Optional CURSOR_SKIP_SOLVED_EN seek FSM:
//   state | meaning
//   IDLE  | cursor accepts moves
//   SEEK  | stepping left/right in raster order past solved cells (busy=1)
module cursor_navigator
  import sudoku_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         up_button,
  input  logic         down_button,
  input  logic         left_button,
  input  logic         right_button,
  input  logic [2:0]   current_state,
  input  logic [161:0] visibilities,
  input  logic [323:0] board,
  output logic [3:0]   row,
  output logic [3:0]   col,
  output logic [7:0]   index,
  output logic [3:0]   cell_value,
  output logic         busy,
  output logic [6:0]   solved_count,
  output logic         board_complete
);

  logic [6:0] k;
  logic [3:0] nxt_row;
  logic [3:0] nxt_col;
  logic       loading;

  assign loading    = (current_state == CARREGANDO);
  assign cell_value = board[{k, 2'b00} +: 4];

  always_comb begin
    nxt_row = row;
    nxt_col = col;
    if (up_button)
      nxt_row = (row == 4'd0) ? 4'd8 : row - 4'd1;
    else if (down_button)
      nxt_row = (row == 4'd8) ? 4'd0 : row + 4'd1;
`ifndef CURSOR_SKIP_SOLVED_EN
    else if (left_button)
      nxt_col = (col == 4'd0) ? 4'd8 : col - 4'd1;
    else if (right_button)
      nxt_col = (col == 4'd8) ? 4'd0 : col + 4'd1;
`endif
  end

`ifdef CURSOR_SKIP_SOLVED_EN

  typedef enum logic {IDLE, SEEK} seek_t;

  seek_t      seek_state;
  logic [6:0] cand;
  logic [6:0] cand_next;
  logic       seek_fwd;
  logic       cand_solved;
  logic       seek_start;

  assign cand_next   = raster_step(cand, seek_fwd);
  assign cand_solved = (visibilities[{cand, 1'b0} +: 2] == SOLVED);
  assign seek_start  = !up_button && !down_button && (left_button || right_button);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row        <= 4'd0;
      col        <= 4'd0;
      k          <= 7'd0;
      index      <= 8'd0;
      busy       <= 1'b0;
      seek_state <= IDLE;
      seek_fwd   <= 1'b0;
      cand       <= 7'd0;
    end else if (loading) begin
      row        <= 4'd0;
      col        <= 4'd0;
      k          <= 7'd0;
      index      <= 8'd0;
      busy       <= 1'b0;
      seek_state <= IDLE;
    end else if (seek_state == SEEK) begin
      if (current_state != NAVEGAR) begin
        busy       <= 1'b0;
        seek_state <= IDLE;
      end else if (!cand_solved) begin
        row        <= row_of(cand);
        col        <= col_of(cand);
        k          <= cand;
        index      <= index_of(cand);
        busy       <= 1'b0;
        seek_state <= IDLE;
      end else if (cand_next == k) begin
        // Every other cell is solved: the walk came back home.
        busy       <= 1'b0;
        seek_state <= IDLE;
      end else begin
        cand <= cand_next;
      end
    end else if (current_state == NAVEGAR) begin
      if (seek_start) begin
        busy       <= 1'b1;
        seek_state <= SEEK;
        seek_fwd   <= !left_button;
        cand       <= raster_step(k, !left_button);
      end else begin
        row   <= nxt_row;
        col   <= nxt_col;
        k     <= cell_of(nxt_row, nxt_col);
        index <= index_of(cell_of(nxt_row, nxt_col));
      end
    end
  end

`else

  assign busy = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row   <= 4'd0;
      col   <= 4'd0;
      k     <= 7'd0;
      index <= 8'd0;
    end else if (loading) begin
      row   <= 4'd0;
      col   <= 4'd0;
      k     <= 7'd0;
      index <= 8'd0;
    end else if (current_state == NAVEGAR) begin
      row   <= nxt_row;
      col   <= nxt_col;
      k     <= cell_of(nxt_row, nxt_col);
      index <= index_of(cell_of(nxt_row, nxt_col));
    end
  end

`endif

  solved_scanner u_scanner (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (loading),
    .visibilities   (visibilities),
    .solved_count   (solved_count),
    .board_complete (board_complete)
  );

endmodule

// File: tb/tb_cursor_navigator.sv
// Self-checking bench for cursor_navigator: directed vector table, scanner
// timing sequences, randomized moves against a grid model, and seek cases.
module tb_cursor_navigator;
  import sudoku_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         up_button, down_button, left_button, right_button;
  logic [2:0]   current_state;
  logic [161:0] visibilities;
  logic [323:0] board;
  logic [3:0]   row, col, cell_value;
  logic [7:0]   index;
  logic         busy;
  logic [6:0]   solved_count;
  logic         board_complete;

  int errors = 0;
  int checks = 0;

  cursor_navigator dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .up_button      (up_button),
    .down_button    (down_button),
    .left_button    (left_button),
    .right_button   (right_button),
    .current_state  (current_state),
    .visibilities   (visibilities),
    .board          (board),
    .row            (row),
    .col            (col),
    .index          (index),
    .cell_value     (cell_value),
    .busy           (busy),
    .solved_count   (solved_count),
    .board_complete (board_complete)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_cursor(input string name, input int r, input int c);
    int kk;
    logic [3:0] ev;
    kk = r * 9 + c;
    ev = board[4*kk +: 4];
    check({name, "_row"},   32'(row),        32'(r));
    check({name, "_col"},   32'(col),        32'(c));
    check({name, "_index"}, 32'(index),      32'(2 * kk));
    check({name, "_value"}, 32'(cell_value), 32'(ev));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input logic [2:0] st, input logic u, input logic d,
                       input logic l, input logic r);
    current_state = st;
    up_button = u; down_button = d; left_button = l; right_button = r;
    step();
    up_button = 0; down_button = 0; left_button = 0; right_button = 0;
  endtask

  task automatic seek(input logic fwd, output int cyc);
    current_state = NAVEGAR;
    right_button = fwd;
    left_button  = !fwd;
    step();
    right_button = 0;
    left_button  = 0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      step();
    end
  endtask

  typedef struct {
    logic [2:0] st;
    logic u, d, l, r;
    int er, ec;
  } vec_t;

  vec_t vt[$];

  initial begin
    int mr, mc, nsolved, cyc;

    reset_n = 1'b0;
    up_button = 0; down_button = 0; left_button = 0; right_button = 0;
    current_state = CARREGANDO;
    visibilities = '0;
    for (int i = 0; i < 81; i++) board[4*i +: 4] = 4'($urandom_range(1, 9));

    repeat (3) @(negedge clk);
    check_cursor("reset", 0, 0);
    check("reset_busy",     32'(busy),           0);
    check("reset_solved",   32'(solved_count),   0);
    check("reset_complete", 32'(board_complete), 0);
    reset_n = 1'b1;
    @(negedge clk);

`ifndef CURSOR_SKIP_SOLVED_EN
    vt.push_back('{NAVEGAR, 0, 0, 0, 1, 0, 1});
    vt.push_back('{NAVEGAR, 0, 0, 1, 0, 0, 0});
    vt.push_back('{NAVEGAR, 1, 0, 0, 0, 8, 0});
    vt.push_back('{NAVEGAR, 0, 0, 1, 0, 8, 8});
    vt.push_back('{NAVEGAR, 0, 1, 0, 0, 0, 8});
    vt.push_back('{NAVEGAR, 0, 0, 0, 1, 0, 0});
    vt.push_back('{NAVEGAR, 0, 0, 1, 1, 0, 8});
    vt.push_back('{NAVEGAR, 1, 1, 0, 0, 8, 8});
    vt.push_back('{PERCORRER_NUMEROS, 1, 0, 0, 0, 8, 8});
    vt.push_back('{PERCORRER_NUMEROS, 0, 0, 0, 1, 8, 8});
    vt.push_back('{CARREGANDO, 0, 0, 0, 0, 0, 0});
    vt.push_back('{NAVEGAR, 0, 1, 0, 0, 1, 0});
    vt.push_back('{NAVEGAR, 0, 1, 0, 0, 2, 0});
    vt.push_back('{NAVEGAR, 0, 1, 0, 0, 3, 0});
    vt.push_back('{NAVEGAR, 0, 1, 0, 0, 4, 0});
    vt.push_back('{NAVEGAR, 0, 0, 0, 1, 4, 1});
    vt.push_back('{NAVEGAR, 0, 0, 0, 1, 4, 2});
    vt.push_back('{NAVEGAR, 0, 0, 0, 1, 4, 3});
    vt.push_back('{NAVEGAR, 0, 0, 0, 1, 4, 4});
    vt.push_back('{NAVEGAR, 1, 0, 0, 1, 3, 4});
    vt.push_back('{3'b000, 1, 0, 0, 0, 3, 4});
    vt.push_back('{NAVEGAR, 0, 1, 1, 1, 4, 4});
    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].st, vt[i].u, vt[i].d, vt[i].l, vt[i].r);
      check_cursor($sformatf("vec%0d", i), vt[i].er, vt[i].ec);
      check($sformatf("vec%0d_busy", i), 32'(busy), 0);
    end
`endif

    // Scanner: exact publish point after loading, then reload clears.
    apply(CARREGANDO, 0, 0, 0, 0);
    visibilities = '1;
    current_state = PERCORRER_NUMEROS;
    repeat (80) step();
    check("scan_hold_count", 32'(solved_count),   0);
    check("scan_hold_done",  32'(board_complete), 0);
    step();
    check("scan_full_count", 32'(solved_count),   81);
    check("scan_full_done",  32'(board_complete), 1);
    apply(CARREGANDO, 0, 0, 0, 0);
    check("load_count", 32'(solved_count),   0);
    check("load_done",  32'(board_complete), 0);
    check_cursor("load", 0, 0);

    visibilities[2*40 +: 2] = 2'b01;
    current_state = PERCORRER_NUMEROS;
    repeat (162) step();
    check("scan80_count", 32'(solved_count),   80);
    check("scan80_done",  32'(board_complete), 0);

    nsolved = 0;
    for (int i = 0; i < 81; i++) begin
      visibilities[2*i +: 2] = 2'($urandom_range(0, 3));
      if (visibilities[2*i +: 2] == 2'b11) nsolved++;
    end
    repeat (162) step();
    check("scan_rand_count", 32'(solved_count),   32'(nsolved));
    check("scan_rand_done",  32'(board_complete), 32'(nsolved == 81));

`ifndef CURSOR_SKIP_SOLVED_EN
    mr = 0;
    mc = 0;
    for (int n = 0; n < 400; n++) begin
      int sel;
      logic u, d, l, r;
      logic [2:0] st;
      sel = $urandom_range(0, 19);
      st = (sel == 0) ? CARREGANDO : (sel < 14) ? NAVEGAR :
           (sel < 18) ? PERCORRER_NUMEROS : 3'b000;
      u = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) == 0);
      apply(st, u, d, l, r);
      if (st == CARREGANDO) begin
        mr = 0; mc = 0;
      end else if (st == NAVEGAR) begin
        if (u)      mr = (mr + 8) % 9;
        else if (d) mr = (mr + 1) % 9;
        else if (l) mc = (mc + 8) % 9;
        else if (r) mc = (mc + 1) % 9;
      end
      check_cursor($sformatf("rand%0d", n), mr, mc);
    end
    current_state = NAVEGAR;
    #2 reset_n = 1'b0;
    #1;
    check_cursor("async_reset", 0, 0);
    check("async_reset_count", 32'(solved_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
`else
    apply(CARREGANDO, 0, 0, 0, 0);
    visibilities = '0;
    apply(NAVEGAR, 0, 1, 0, 0);
    check_cursor("skip_k9", 1, 0);
    seek(1'b1, cyc);
    check("skip_free_cycles", 32'(cyc), 1);
    check_cursor("skip_k10", 1, 1);

    for (int i = 11; i <= 13; i++) visibilities[2*i +: 2] = 2'b11;
    seek(1'b1, cyc);
    check("skip3_cycles", 32'(cyc), 4);
    check_cursor("skip3_k14", 1, 5);

    visibilities = '0;
    for (int i = 0; i < 4; i++) seek(1'b0, cyc);
    check_cursor("back_k10", 1, 1);

    visibilities = '1;
    seek(1'b1, cyc);
    check("allsolved_cycles", 32'(cyc), 80);
    check_cursor("allsolved_stay", 1, 1);

    current_state = NAVEGAR;
    right_button = 1'b1;
    step();
    right_button = 1'b0;
    repeat (5) step();
    check("abort_busy_before", 32'(busy), 1);
    current_state = PERCORRER_NUMEROS;
    step();
    check("abort_busy_after", 32'(busy), 0);
    check_cursor("abort_stay", 1, 1);

    current_state = NAVEGAR;
    left_button = 1'b1;
    step();
    left_button = 1'b0;
    repeat (10) step();
    check("midseek_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    check_cursor("midseek_reset", 0, 0);
    check("midseek_reset_busy", 32'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
